// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Holds the program counter, presents it to the instruction memory, and
// captures the returned word plus PC+4 into the IF/ID register. A two-state
// RUN/HALT machine detects the self-loop instruction (B #-1) once it sits in
// IF/ID and freezes the fetch counter from then on.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-low reset
//   freeze       in   1   decode hazard stall: hold PC and IF/ID
//   branch_taken in   1   redirect PC to branch_addr (beats freeze)
//   branch_addr  in  32   branch target byte address (low 2 bits ignored)
//   flush        in   1   squash IF/ID to a bubble (beats freeze)
//   imem_addr    out 32   fetch address (the PC register itself)
//   imem_inst    in  32   instruction word for imem_addr, combinational
//   pc_out       out 32   PC+4 of the instruction held in IF/ID
//   inst_out     out 32   instruction held in IF/ID
//   valid_out    out  1   IF/ID holds a real fetch, not a bubble
//   fetch_count  out 32   instructions accepted into IF/ID while running
//   halted       out  1   self-loop instruction has reached IF/ID
// -----------------------------------------------------------------------------
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic        flush,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        valid_out,
    output logic [31:0] fetch_count,
    output logic        halted
);

    localparam int unsigned XLEN = 32;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    localparam logic [XLEN-1:0] HALT_INST  = 32'hEAFF_FFFF;
    localparam logic [XLEN-1:0] WORD_ALIGN = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] pco_q,   pco_d;
    logic [XLEN-1:0] inst_q,  inst_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] cnt_q,   cnt_d;
    logic [0:0]      state_q, state_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] pc_plus4;
    logic            load;

    assign pc_plus4 = pc_q + INST_BYTES;
    assign load     = !flush && !freeze;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Next state: the halt check looks at the registered IF/ID contents, so a
    // flush in the same cycle cannot hide the self-loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (valid_q && (inst_q == HALT_INST)) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // PC and IF/ID next values; masking keeps fetches word aligned.
    always_comb begin
        pc_d    = pc_q;
        pco_d   = pco_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        if (branch_taken) begin
            pc_d = branch_addr & WORD_ALIGN;
        end else if (!freeze) begin
            pc_d = pc_plus4;
        end

        if (flush) begin
            pco_d   = '0;
            inst_d  = '0;
            valid_d = 1'b0;
        end else if (!freeze) begin
            pco_d   = pc_plus4;
            inst_d  = imem_inst;
            valid_d = 1'b1;
        end

        if (load && (state_q == ST_RUN)) begin
            cnt_d = cnt_q + XLEN'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            pco_q   <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            pco_q   <= pco_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_out      = pco_q;
    assign inst_out    = inst_q;
    assign valid_out   = valid_q;
    assign fetch_count = cnt_q;
    assign halted      = halted_q;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 freeze  input  1  hazard stall from decode; holds PC and IF/ID register.
REQ-005 branch_taken  input  1  branch resolved taken in execute; redirects PC.
REQ-006 branch_addr  input  32  branch target byte address.
REQ-007 flush  input  1  squash the IF/ID register contents.
REQ-008 imem_addr  output  32  fetch address to the instruction memory.
REQ-009 imem_inst  input  32  instruction word returned combinationally for imem_addr.
REQ-010 pc_out  output  32  registered PC+4 of the instruction in IF/ID.
REQ-011 inst_out  output  32  registered instruction to decode.
REQ-012 valid_out  output  1  inst_out holds a real (non-bubble) fetch.
REQ-013 fetch_count  output  32  number of instructions accepted into IF/ID since reset.
REQ-014 halted  output  1  self-loop instruction (32'hEAFFFFFF, B #-1) has reached IF/ID.

Function
REQ-015 imem_addr SHALL equal the PC register combinationally, bits [1:0] always 0.
REQ-016 PC next-value priority: branch_taken -> {branch_addr[31:2],2'b00}; else freeze -> hold; else PC+4.
REQ-017 branch_taken SHALL override freeze in the same cycle.
REQ-018 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000), no flag.
REQ-019 IF/ID update priority: flush -> inst_out=0, pc_out=0, valid_out=0; else freeze -> hold all; else load inst_out=imem_inst, pc_out=PC+4, valid_out=1.
REQ-020 flush SHALL override freeze in the same cycle.
REQ-021 Fetch-to-decode latency: word at imem_addr in cycle N appears on inst_out after the rising edge ending cycle N.
REQ-022 fetch_count SHALL increment by 1 on each edge where IF/ID loads (not flush, not freeze) and state is RUN; wraps modulo 2^32.
REQ-023 State machine, two states: RUN, HALT.
REQ-024 RUN -> HALT on the edge after which valid_out=1 and inst_out=32'hEAFFFFFF (evaluated on registered IF/ID contents, i.e. one cycle after load).
REQ-025 A flush arriving in the same cycle as the HALT transition condition SHALL NOT block the transition (condition uses current registered values).
REQ-026 HALT SHALL be left only by reset; halted=1 exactly while in HALT.
REQ-027 In HALT, PC and IF/ID SHALL keep operating per REQ-016/019; only fetch_count freezes.
REQ-028 All outputs except imem_addr SHALL be registered.

Reset
REQ-029 On rst low, immediately (without clk): PC=0, imem_addr=0, pc_out=0, inst_out=0, valid_out=0, fetch_count=0, state=RUN, halted=0.
REQ-030 On rst deassert, the first rising edge SHALL fetch address 0; reset mid-operation SHALL discard any pending branch/freeze.

Verification
REQ-031 Reset release, no stall, imem returns addr-based words: after 3 edges PC=12, pc_out=12, inst_out=word@8, valid_out=1, fetch_count=3.
REQ-032 freeze=1 for 2 cycles at PC=16: PC stays 16, IF/ID holds, fetch_count unchanged; resumes at PC=20 after release.
REQ-033 branch_taken=1, branch_addr=32'h00000043, freeze=1, flush=1 same cycle: next PC=32'h40, inst_out=0, valid_out=0, fetch_count unchanged.
REQ-034 imem_inst=32'hEAFFFFFF loaded at PC=188: one edge later halted=1, fetch_count stops; PC keeps advancing to 196, 200.
REQ-035 PC forced by branch to 32'hFFFFFFFC: next edge PC=0, pc_out=0 (PC+4 wrap), valid_out=1.
REQ-036 rst pulsed low mid-clock while halted with freeze=1: all outputs 0 asynchronously, halted=0, fetch restarts at address 0.
